// File: rtl/long_pulse_rx.sv
// long_pulse_rx
// Measures the high width of a stretched, asynchronous pulse on Pin and
// classifies it once it completes. Widths in [MIN_LEN, MAX_LEN] raise a
// one-cycle Pout strobe, anything else raises a one-cycle Perr strobe.
// Plen reports the measured width (saturating) and holds until the next strobe.
//
// Optional build macro: LONG_PULSE_RX_TIMEOUT_EN
//   When defined, a pulse that stays high for MAX_LEN+1 cycles is rejected
//   immediately with Perr and Plen=MAX_LEN+1. The FSM then parks in DRAIN
//   until the line drops, so the late falling edge produces no second strobe.
//   When undefined, over-long pulses are only judged at their falling edge.
//
// Handshake: none. Pin is a level input with no ready/valid. Pout and Perr
// are single-cycle strobes with no back-pressure. A consumer must sample
// them on every clock.
//
// The FSM state is exported on dbg_state so that checkers can bind to it.
// Encoding: 0 = IDLE, 1 = MEASURE, 2 = DRAIN (DRAIN exists in timeout builds only).

module long_pulse_rx #(
    parameter int MIN_LEN = 4,
    parameter int MAX_LEN = 6,
    parameter int CNT_W   = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Pin,
    output logic             Pout,
    output logic             Perr,
    output logic [CNT_W-1:0] Plen,
    output logic             Busy,
    output logic [1:0]       dbg_state
);

    // Width thresholds converted once to the counter width.
    localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_LEN);
    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
`ifdef LONG_PULSE_RX_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_C    = CNT_W'(MAX_LEN + 1);
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1
`ifdef LONG_PULSE_RX_TIMEOUT_EN
        ,
        DRAIN   = 2'd2
`endif
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             s_meta;
    logic             s_in;

    assign dbg_state = state;

    // Two-flop synchronizer. Everything downstream looks at s_in only.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            s_meta <= 1'b0;
            s_in   <= 1'b0;
        end else begin
            s_meta <= Pin;
            s_in   <= s_meta;
        end
    end

    // Measurement FSM. All outputs are registered here, and the strobes
    // default low so that they last exactly one cycle.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state <= IDLE;
            count <= '0;
            Pout  <= 1'b0;
            Perr  <= 1'b0;
            Plen  <= '0;
            Busy  <= 1'b0;
        end else begin
            Pout <= 1'b0;
            Perr <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_in) begin
                        // The first high sample already counts as cycle one.
                        state <= MEASURE;
                        count <= CNT_W'(1);
                        Busy  <= 1'b1;
                    end else begin
                        count <= '0;
                        Busy  <= 1'b0;
                    end
                end

                MEASURE: begin
                    if (s_in) begin
`ifdef LONG_PULSE_RX_TIMEOUT_EN
                        if (count == MAX_C) begin
                            // This sample makes the width MAX_LEN+1. Reject now
                            // and wait in DRAIN for the line to fall.
                            count <= TO_C;
                            Plen  <= TO_C;
                            Perr  <= 1'b1;
                            state <= DRAIN;
                            Busy  <= 1'b1;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
`else
                        // Saturate instead of wrapping, so that a very long pulse
                        // cannot look like a short, legal one.
                        if (count != CNT_MAX) begin
                            count <= count + CNT_W'(1);
                        end
`endif
                    end else begin
                        // Falling edge seen: report and return to IDLE. A new
                        // rising edge on the next sample starts a fresh measurement.
                        Plen <= count;
                        if ((count >= MIN_C) && (count <= MAX_C)) begin
                            Pout <= 1'b1;
                        end else begin
                            Perr <= 1'b1;
                        end
                        state <= IDLE;
                        count <= '0;
                        Busy  <= 1'b0;
                    end
                end

`ifdef LONG_PULSE_RX_TIMEOUT_EN
                DRAIN: begin
                    // The pulse has already been reported. Swallow the rest of it.
                    if (!s_in) begin
                        state <= IDLE;
                        count <= '0;
                        Busy  <= 1'b0;
                    end
                end
`endif

                default: begin
                    state <= IDLE;
                    count <= '0;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_long_pulse_rx.sv
// tb_long_pulse_rx
// Self-checking bench for long_pulse_rx (default parameters). Every driven
// pulse pushes its expected {is_err, Plen} onto a queue. A monitor pops and
// compares that entry each time the DUT strobes.

module tb_long_pulse_rx;

    localparam int MIN_LEN = 4;
    localparam int MAX_LEN = 6;
    localparam int CNT_W   = 4;
    localparam int W       = CNT_W + 1;
    localparam int SAT     = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             pin;
    logic             pout;
    logic             perr;
    logic [CNT_W-1:0] plen;
    logic             busy;
    logic [1:0]       dbg_state;

    logic [W-1:0] exp_q[$];
    int           n_checks;
    int           n_fail;

    long_pulse_rx #(
        .MIN_LEN(MIN_LEN),
        .MAX_LEN(MAX_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .Clk      (clk),
        .Rst_n    (rst_n),
        .Pin      (pin),
        .Pout     (pout),
        .Perr     (perr),
        .Plen     (plen),
        .Busy     (busy),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: expected {is_err, Plen} for a pulse of n high cycles.
    function automatic logic [W-1:0] exp_of(input int n);
        logic           err;
        int             len;
`ifdef LONG_PULSE_RX_TIMEOUT_EN
        if (n > MAX_LEN) begin
            return {1'b1, CNT_W'(MAX_LEN + 1)};
        end
`endif
        len = (n > SAT) ? SAT : n;
        err = !((n >= MIN_LEN) && (n <= MAX_LEN));
        return {err, CNT_W'(len)};
    endfunction

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (pout && perr) check_eq("pout_perr_exclusive", 32'd1, 32'd0);
            if (pout || perr) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("strobe_is_err", 32'(perr), 32'(e[CNT_W]));
                    check_eq("strobe_plen", 32'(plen), 32'(e[CNT_W-1:0]));
                end
            end
        end
    end

    // ---------------- drivers ----------------
    // Pin is held high for n clock cycles, then low for gap cycles.
    task automatic pulse(input int n, input int gap);
        @(negedge clk);
        pin = 1'b1;
        exp_q.push_back(exp_of(n));
        repeat (n) @(negedge clk);
        pin = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Same as pulse(), plus checks on Busy, on strobe latency and width, and
    // on Plen holding afterwards. Use only for n <= MAX_LEN and gap >= 4.
    task automatic pulse_timed(input int n, input int gap);
        logic [W-1:0] e;
        e = exp_of(n);
        @(negedge clk);
        pin = 1'b1;
        exp_q.push_back(e);
        repeat (n) @(negedge clk);
        pin = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq($sformatf("busy_measuring_n%0d", n), 32'(busy), 32'd1);
        check_eq($sformatf("no_early_strobe_n%0d", n), 32'(pout | perr), 32'd0);
        @(negedge clk);
        check_eq($sformatf("strobe_at_3_edges_n%0d", n), 32'(pout | perr), 32'd1);
        check_eq($sformatf("busy_low_after_n%0d", n), 32'(busy), 32'd0);
        @(negedge clk);
        check_eq($sformatf("strobe_one_cycle_n%0d", n), 32'(pout | perr), 32'd0);
        repeat (gap - 3) @(negedge clk);
        check_eq($sformatf("plen_hold_n%0d", n), 32'(plen), 32'(e[CNT_W-1:0]));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        pin      = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_pout", 32'(pout), 32'd0);
        check_eq("rst_perr", 32'(perr), 32'd0);
        check_eq("rst_plen", 32'(plen), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal width, too short, both boundaries, and just outside them
        pulse_timed(5, 5);
        pulse_timed(2, 5);
        pulse_timed(4, 5);
        pulse_timed(6, 5);
        pulse_timed(3, 5);
        pulse(7, 6);
        pulse(1, 6);

        // Over-long pulse: saturates at the falling edge, or times out early
        pulse(20, 8);

        // Back-to-back pulses with a single low cycle between them
        pulse(5, 1);
        pulse(5, 6);

        // Reset during the 3rd high cycle of a 5-cycle pulse. The abandoned
        // part gives no strobe. The 2 high cycles after release are measured
        // as a new pulse.
        @(negedge clk);
        pin = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst_pout", 32'(pout), 32'd0);
        check_eq("midrst_perr", 32'(perr), 32'd0);
        check_eq("midrst_plen", 32'(plen), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        exp_q.push_back(exp_of(2));
        @(negedge clk);
        @(negedge clk);
        pin = 1'b0;
        repeat (6) @(negedge clk);

        // Random widths and gaps
        for (int i = 0; i < 40; i++) begin
            pulse($urandom_range(20, 1), $urandom_range(10, 1));
        end

        // Let the last strobe arrive, then confirm that nothing is outstanding.
        repeat (10) @(negedge clk);
        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
